// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// fetch-queue head handed to decode.
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_instr;

  modport master (
    output imem_req_valid, imem_req_addr, f_valid, f_pc, f_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, f_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, f_valid, f_pc, f_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, f_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Credit-based instruction fetch: issues sequential PCs, queues in-order
// responses as {pc, instr}, and flushes/drains on a redirect.
module if_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCSrc,
  input  logic [XLEN-1:0]   PCTarget,
  if_fetch_unit_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] f_pc_q, f_pc_d;
  logic [XLEN-1:0] f_instr_q, f_instr_d;
  logic [XLEN-1:0] ent_pc_q    [DEPTH];
  logic [XLEN-1:0] ent_instr_q [DEPTH];

  logic            credit_ok;
  logic            req_fire;
  logic            pop;
  logic            rsp_keep;
  logic [XLEN-1:0] target;

  // Sum of in-flight and queued entries must leave room for every response.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);

  assign bus.imem_req_valid = rst_n && credit_ok && !PCSrc;
  assign bus.imem_req_addr  = pc_q;
  assign bus.f_valid        = (count_q != '0);
  assign bus.f_pc           = f_pc_q;
  assign bus.f_instr        = f_instr_q;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign pop      = bus.f_valid && bus.f_ready && !PCSrc;
  assign rsp_keep = bus.imem_rsp_valid && (discard_q == '0) && !PCSrc;
  assign target   = {PCTarget[XLEN-1:2], 2'b00};

  // Implicit modes from discard_q:
  //   RUN   | discard = 0, responses land in the queue
  //   DRAIN | discard > 0, stale responses from the old path are dropped
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    f_pc_d        = f_pc_q;
    f_instr_d     = f_instr_q;

    if (PCSrc) begin
      pc_d      = target;
      rsp_pc_d  = target;
      discard_d = outstanding_d;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (req_fire)
        pc_d = pc_q + XLEN'(PC_STEP);
      if (bus.imem_rsp_valid && (discard_q != '0))
        discard_d = discard_q - CW'(1);
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(rsp_keep) - CW'(pop);

      // The incoming write becomes the head only when the queue drains to it.
      if (rsp_keep && (wr_ptr_q == rd_ptr_d)) begin
        f_pc_d    = rsp_pc_q;
        f_instr_d = bus.imem_rsp_data;
      end else begin
        f_pc_d    = ent_pc_q[rd_ptr_d];
        f_instr_d = ent_instr_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      f_pc_q        <= '0;
      f_instr_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      f_pc_q        <= f_pc_d;
      f_instr_q     <= f_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      ent_pc_q[wr_ptr_q]    <= rsp_pc_q;
      ent_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: memory model with per-request latency,
// path epochs to recognise stale responses, expected fetch-queue contents.
module tb_if_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;

  if_fetch_unit_if #(.XLEN(XLEN)) bus ();

  if_fetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .bus(bus.master)
  );

  always #5 clk = ~clk;

  mreq_t       mem_q[$];
  fent_t       exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          n_req = 0;
  int          lat = 1;
  bit          f_rdy = 1'b1;
  bit          rdy_rand = 1'b0;
  bit          redir_req = 1'b0;
  bit          redir_busy = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_pc = RESET_PC;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    mreq_t r;
    fent_t e;
    bit    rsp;
    bit    pcs;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_q[0].data : '0;
    bus.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.f_ready        = f_rdy;
    pcs      = redir_req || (redir_busy && rsp && exp_q.size() != 0);
    PCSrc    = pcs;
    PCTarget = redir_tgt;
    #1;
    chk("req_valid", 32'(bus.imem_req_valid),
        32'((mem_q.size() + exp_q.size() < DEPTH) && !pcs));
    chk("f_valid", 32'(bus.f_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0 && f_rdy && !pcs) begin
      e = exp_q.pop_front();
      chk("f_pc", bus.f_pc, e.pc);
      chk("f_instr", bus.f_instr, e.instr);
    end
    if (rsp) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !pcs) begin
        chk("no_overflow", 32'(exp_q.size() < DEPTH), 32'd1);
        e.pc    = r.addr;
        e.instr = r.data;
        exp_q.push_back(e);
      end
    end
    if (pcs) begin
      exp_q.delete();
      epoch++;
      exp_pc     = redir_tgt & 32'hFFFF_FFFC;
      redir_req  = 1'b0;
      redir_busy = 1'b0;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_pc);
      r.addr  = exp_pc;
      r.data  = $urandom;
      r.epoch = epoch;
      r.due   = cyc + lat;
      mem_q.push_back(r);
      exp_pc = exp_pc + 32'd4;
      n_req++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b1;
    bus.f_ready        = 1'b0;
    PCSrc              = 1'b0;
    PCTarget           = '0;
  endtask

  // Assert reset now (may be between edges), check outputs, release at a falling edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk({tag, "_f_valid"}, 32'(bus.f_valid), 32'd0);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    chk({tag, "_f_pc"}, bus.f_pc, 32'd0);
    chk({tag, "_f_instr"}, bus.f_instr, 32'd0);
    mem_q.delete();
    exp_q.delete();
    epoch++;
    exp_pc     = RESET_PC;
    n_req      = 0;
    redir_req  = 1'b0;
    redir_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);

    // Reset, then streaming with 1-cycle latency and random request stalls
    do_reset("rst");
    lat = 1; f_rdy = 1'b1;
    repeat (12) cycle();
    rdy_rand = 1'b1;
    repeat (20) cycle();
    rdy_rand = 1'b0;

    // Backpressure to full
    do_reset("rst_bp");
    f_rdy = 1'b0;
    repeat (10) cycle();
    chk("bp_reqs", 32'(n_req), 32'd4);
    chk("bp_full", 32'(exp_q.size()), 32'd4);
    f_rdy = 1'b1;
    repeat (12) cycle();

    // Redirect with two requests in flight
    do_reset("rst_rd");
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle();
    chk("rd_inflight", 32'(mem_q.size()), 32'd2);
    redir_tgt = 32'h0000_0100; redir_req = 1'b1;
    repeat (16) cycle();

    // Misaligned target near the top of the address space wraps to zero
    redir_tgt = 32'hFFFF_FFFE; redir_req = 1'b1;
    repeat (12) cycle();

    // Redirect coinciding with a response and a pop
    lat = 1; f_rdy = 1'b1;
    repeat (4) cycle();
    redir_tgt = 32'h0000_0200; redir_busy = 1'b1;
    for (int i = 0; i < 20 && redir_busy; i++) cycle();
    chk("simul_hit", 32'(redir_busy), 32'd0);
    repeat (8) cycle();

    // Asynchronous reset mid-stream with three queued entries
    do_reset("rst_pre");
    lat = 1; f_rdy = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() < 3; i++) cycle();
    chk("ar_three", 32'(exp_q.size()), 32'd3);
    #2;
    do_reset("rst_async");
    f_rdy = 1'b1;
    repeat (10) cycle();
    chk("ar_restart", 32'(n_req > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
